ov_sccb_slave: RTL and testbench
================================

OV_SCCB_SLAVE -- requirements
Module: ov_sccb_slave

Interface
REQ-001 Parameter CHIP_ADDR, default 8'hCD, 7-bit device ID in bits [7:1]; bit 0 ignored.
REQ-002 clk  input  1  system clock; the only clock; frequency SHALL be at least 16x the sio_c rate.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 sio_c  input  1  SCCB clock from the master, asynchronous to clk.
REQ-005 sio_d  inout  1  SCCB data, open-drain; the block drives only 0 or Z.
REQ-006 reg_addr  output  8  register sub-address presented to the register bank.
REQ-007 reg_wdata  output  8  write data.
REQ-008 reg_we  output  1  one-clk write strobe.
REQ-009 reg_re  output  1  one-clk read strobe.
REQ-010 reg_rdata  input  8  read data, valid on the clk after reg_re.
REQ-011 busy  output  1  high from START until STOP or abort.

Function
REQ-012 sio_c and sio_d SHALL each pass through a 2-flop synchronizer; all decoding SHALL use the synchronized copies and edge detects.
REQ-013 START = synced sio_d falls while synced sio_c is high; STOP = synced sio_d rises while synced sio_c is high.
REQ-014 Bits SHALL be sampled on synced sio_c rising edges, MSB first; sio_d drive changes SHALL occur only on synced sio_c falling edges.
REQ-015 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RNACK, IGNORE.
REQ-016 START in any state SHALL go to ADDR, clear the bit counter and release sio_d (repeated start supported).
REQ-017 STOP in any state SHALL go to IDLE, release sio_d and deassert busy; no strobe for a partial byte.
REQ-018 ADDR: after 8 bits, if byte[7:1]==CHIP_ADDR[7:1] -> ADDR_ACK, else -> IGNORE without driving sio_d.
REQ-019 ACK states: drive sio_d low from the falling edge after bit 8 to the falling edge after bit 9.
REQ-020 ADDR_ACK exit: R/W=0 -> SUB; R/W=1 -> RDATA.
REQ-021 SUB: 8 bits loaded into reg_addr at bit 8; -> SUB_ACK -> WDATA. A 2-phase write ends here at STOP with no strobe.
REQ-022 WDATA: at bit 8, reg_wdata <= byte and reg_we pulses one clk; -> WDATA_ACK -> IGNORE. Extra bytes are not acked and cause no strobe; there is no auto-increment.
REQ-023 RDATA: reg_re pulses one clk on entry; reg_rdata is captured on the next clk into the shift register; the 8 bits are driven MSB first (a 0 bit drives low, a 1 bit releases).
REQ-024 RNACK: release sio_d for the 9th bit regardless of the master's NA; -> IGNORE.
REQ-025 reg_addr SHALL persist across transactions, so a 2-phase read uses the last written sub-address.
REQ-026 IGNORE: sio_d released; wait for START or STOP.
REQ-027 reg_we and reg_re SHALL never be high on the same clk.

Reset
REQ-028 While reset is low: state=IDLE, sio_d=Z, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, and synchronizers set to 1 (idle bus).
REQ-029 Reset asserted mid-transaction SHALL release sio_d immediately (asynchronously); after release, the block ignores the bus until the next START.

Configuration
REQ-030 Macro SCCB_SLV_READ_EN defined: read path (RDATA, RNACK, reg_re) is present as specified.
REQ-031 Macro SCCB_SLV_READ_EN undefined: an address byte with R/W=1 SHALL be treated as a mismatch (no ACK -> IGNORE); reg_re is tied to 0; RDATA/RNACK logic is removed.

Verification
REQ-032 Write 0xCC,0x12,0x80 then STOP -> sio_d low in all 3 ACK slots; one reg_we pulse with reg_addr=0x12, reg_wdata=0x80.
REQ-033 Address 0x42 (mismatch) -> sio_d never driven; no reg_we; busy stays high until STOP.
REQ-034 Write 0xCC,0x0A, STOP, then 0xCD with reg_rdata=0x76 -> reg_re pulse; data bits driven 0,1,1,1,0,1,1,0; sio_d released in the NA slot.
REQ-035 STOP after 4 bits of WDATA -> IDLE, no reg_we, reg_addr keeps its sub-address.
REQ-036 Reset low during the SUB_ACK low-drive -> sio_d Z in the same clk; the next full write completes normally.
REQ-037 SCCB_SLV_READ_EN undefined, address 0xCD -> no ACK, reg_re=0, sio_d Z throughout.

Source files
------------

// File: rtl/ov_sccb_slave.sv
// SCCB slave feeding a simple register bank: synchronized sio_c/sio_d, one-clk reg_we/reg_re strobes, no backpressure.
// Read path (RDATA/RNACK states, reg_re) exists only when SCCB_SLV_READ_EN is defined.
module ov_sccb_slave #(
    parameter logic [7:0] CHIP_ADDR = 8'hCD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sio_c,
    inout  wire        sio_d,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RNACK, IGNORE
    } state_t;

    state_t     state_q;
    logic [2:0] c_q, d_q;
    logic [3:0] cnt_q;
    logic [7:0] shreg_q;
    logic       sd_oe_q;
    logic       busy_q;
    logic       reg_we_q;
    logic [7:0] reg_addr_q, reg_wdata_q;
`ifdef SCCB_SLV_READ_EN
    logic       reg_re_q;
    logic       rd_load_q;
`endif

    logic       scl_rise, scl_fall, start_det, stop_det, byte_done, addr_hit;
    logic [7:0] byte_w;

    // [1] is the synchronized copy, [2] its previous value for edge detection
    assign scl_rise  = c_q[1] & ~c_q[2];
    assign scl_fall  = ~c_q[1] & c_q[2];
    assign start_det = c_q[1] & c_q[2] & d_q[2] & ~d_q[1];
    assign stop_det  = c_q[1] & c_q[2] & ~d_q[2] & d_q[1];
    assign byte_w    = {shreg_q[6:0], d_q[1]};
    assign byte_done = scl_rise && (cnt_q == 4'd7);

`ifdef SCCB_SLV_READ_EN
    assign addr_hit = (byte_w[7:1] == CHIP_ADDR[7:1]);
    assign reg_re   = reg_re_q;
`else
    assign addr_hit = (byte_w[7:1] == CHIP_ADDR[7:1]) && !byte_w[0];
    assign reg_re   = 1'b0;
    logic unused_rdata;
    assign unused_rdata = ^reg_rdata;
`endif

    assign sio_d     = sd_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            c_q         <= 3'b111;
            d_q         <= 3'b111;
            cnt_q       <= 4'd0;
            shreg_q     <= 8'd0;
            sd_oe_q     <= 1'b0;
            busy_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
`ifdef SCCB_SLV_READ_EN
            reg_re_q    <= 1'b0;
            rd_load_q   <= 1'b0;
`endif
        end else begin
            c_q      <= {c_q[1:0], sio_c};
            d_q      <= {d_q[1:0], sio_d};
            reg_we_q <= 1'b0;
`ifdef SCCB_SLV_READ_EN
            reg_re_q  <= 1'b0;
            rd_load_q <= reg_re_q;
`endif
            if (start_det) begin
                state_q <= ADDR;
                cnt_q   <= 4'd0;
                sd_oe_q <= 1'b0;
                busy_q  <= 1'b1;
            end else if (stop_det) begin
                state_q <= IDLE;
                cnt_q   <= 4'd0;
                sd_oe_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        shreg_q <= byte_w;
                        cnt_q   <= byte_done ? 4'd0 : cnt_q + 4'd1;
                        if (byte_done) state_q <= addr_hit ? ADDR_ACK : IGNORE;
                    end
                    SUB: if (scl_rise) begin
                        shreg_q <= byte_w;
                        cnt_q   <= byte_done ? 4'd0 : cnt_q + 4'd1;
                        if (byte_done) begin
                            reg_addr_q <= byte_w;
                            state_q    <= SUB_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg_q <= byte_w;
                        cnt_q   <= byte_done ? 4'd0 : cnt_q + 4'd1;
                        if (byte_done) begin
                            reg_wdata_q <= byte_w;
                            reg_we_q    <= 1'b1;
                            state_q     <= WDATA_ACK;
                        end
                    end
                    // ACK slot: first falling edge grabs the line, second releases it
                    ADDR_ACK: if (scl_fall) begin
                        sd_oe_q <= ~sd_oe_q;
                        if (sd_oe_q) begin
`ifdef SCCB_SLV_READ_EN
                            if (shreg_q[0]) begin
                                state_q  <= RDATA;
                                reg_re_q <= 1'b1;
                            end else begin
                                state_q <= SUB;
                            end
`else
                            state_q <= SUB;
`endif
                        end
                    end
                    SUB_ACK: if (scl_fall) begin
                        sd_oe_q <= ~sd_oe_q;
                        if (sd_oe_q) state_q <= WDATA;
                    end
                    WDATA_ACK: if (scl_fall) begin
                        sd_oe_q <= ~sd_oe_q;
                        if (sd_oe_q) state_q <= IGNORE;
                    end
`ifdef SCCB_SLV_READ_EN
                    // Bank data lands a clk after reg_re; the first bit goes out well inside the low phase
                    RDATA: begin
                        if (rd_load_q) begin
                            shreg_q <= reg_rdata;
                            sd_oe_q <= ~reg_rdata[7];
                        end else if (scl_rise) begin
                            cnt_q <= cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                sd_oe_q <= 1'b0;
                                state_q <= RNACK;
                            end else begin
                                shreg_q <= {shreg_q[6:0], 1'b0};
                                sd_oe_q <= ~shreg_q[6];
                            end
                        end
                    end
                    RNACK: if (scl_fall) state_q <= IGNORE;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov_sccb_slave.sv
// Directed bench for ov_sccb_slave: bit-banged SCCB master on a pulled-up open-drain sio_d.
// Works for both builds; the read-path scenario follows SCCB_SLV_READ_EN.
module tb_ov_sccb_slave;

    localparam time Q = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_c = 1'b1;
    logic       m_d = 1'b1;
    logic [7:0] reg_rdata = 8'h00;
    wire        sio_d;
    wire  [7:0] reg_addr, reg_wdata;
    wire        reg_we, reg_re, busy;

    assign sio_d = m_d ? 1'bz : 1'b0;
    pullup (sio_d);

    always #5 clk = ~clk;

    ov_sccb_slave #(.CHIP_ADDR(8'hCD)) dut (
        .clk       (clk),
        .reset     (reset),
        .sio_c     (m_c),
        .sio_d     (sio_d),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int         we_cnt = 0, re_cnt = 0, drv_cnt = 0, both_cnt = 0;
    logic [7:0] we_addr = 8'h00, we_data = 8'h00;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
        end
        if (reg_re) re_cnt <= re_cnt + 1;
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
        if (m_d && sio_d === 1'b0) drv_cnt <= drv_cnt + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic sccb_start();
        m_d = 1'b1; #Q;
        m_c = 1'b1; #Q;
        m_d = 1'b0; #Q;
        m_c = 1'b0; #Q;
    endtask

    task automatic sccb_stop();
        m_c = 1'b0; m_d = 1'b0; #Q;
        m_c = 1'b1; #Q;
        m_d = 1'b1; #Q;
    endtask

    task automatic bit_io(input logic b, output logic s);
        m_d = b;    #Q;
        m_c = 1'b1; #Q;
        s = sio_d;  #Q;
        m_c = 1'b0; #Q;
    endtask

    task automatic byte_wr(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        ack = ~s;
    endtask

    task automatic byte_rd(output logic [7:0] d, output logic na_lvl);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(1'b1, na_lvl);
    endtask

    initial begin
        logic       a0, a1, a2, a3, s, na;
        logic [7:0] rd;
        int         we0, re0, drv0;

        #22;
        check("rst_addr",  32'(reg_addr),  32'h00);
        check("rst_wdata", 32'(reg_wdata), 32'h00);
        check("rst_we",    32'(reg_we),    32'h0);
        check("rst_re",    32'(reg_re),    32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_sio_d", 32'(sio_d),     32'h1);
        reset = 1'b1;
        #(2*Q);

        // 3-phase write
        we0 = we_cnt; re0 = re_cnt;
        sccb_start();
        byte_wr(8'hCC, a0);
        check("wr_busy", 32'(busy), 32'h1);
        byte_wr(8'h12, a1);
        byte_wr(8'h80, a2);
        sccb_stop();
        check("wr_ack_addr", 32'(a0), 32'h1);
        check("wr_ack_sub",  32'(a1), 32'h1);
        check("wr_ack_data", 32'(a2), 32'h1);
        check("wr_we_count", 32'(we_cnt - we0), 32'd1);
        check("wr_we_addr",  32'(we_addr), 32'h12);
        check("wr_we_data",  32'(we_data), 32'h80);
        check("wr_no_re",    32'(re_cnt - re0), 32'd0);
        check("wr_busy_end", 32'(busy), 32'h0);

        // extra data byte: no ACK, no second strobe
        we0 = we_cnt;
        sccb_start();
        byte_wr(8'hCC, a0); byte_wr(8'h20, a1); byte_wr(8'h55, a2); byte_wr(8'h66, a3);
        sccb_stop();
        check("xtra_ack_data", 32'(a2), 32'h1);
        check("xtra_no_ack",   32'(a3), 32'h0);
        check("xtra_we_count", 32'(we_cnt - we0), 32'd1);
        check("xtra_we_data",  32'(we_data), 32'h55);
        check("xtra_reg_addr", 32'(reg_addr), 32'h20);

        // address mismatch
        we0 = we_cnt; drv0 = drv_cnt;
        sccb_start();
        byte_wr(8'h42, a0);
        check("miss_busy1", 32'(busy), 32'h1);
        byte_wr(8'h12, a1);
        check("miss_busy2", 32'(busy), 32'h1);
        sccb_stop();
        check("miss_ack_addr", 32'(a0), 32'h0);
        check("miss_ack_sub",  32'(a1), 32'h0);
        check("miss_no_drive", 32'(drv_cnt - drv0), 32'd0);
        check("miss_no_we",    32'(we_cnt - we0), 32'd0);
        check("miss_busy_end", 32'(busy), 32'h0);

        // STOP after 4 bits of the data byte
        we0 = we_cnt;
        sccb_start();
        byte_wr(8'hCC, a0); byte_wr(8'h34, a1);
        bit_io(1'b1, s); bit_io(1'b0, s); bit_io(1'b1, s); bit_io(1'b0, s);
        sccb_stop();
        check("part_no_we",    32'(we_cnt - we0), 32'd0);
        check("part_reg_addr", 32'(reg_addr), 32'h34);
        check("part_busy",     32'(busy), 32'h0);

        // repeated START restarts the transaction
        we0 = we_cnt;
        sccb_start();
        byte_wr(8'hCC, a0); byte_wr(8'h3C, a1);
        sccb_start();
        byte_wr(8'hCC, a0); byte_wr(8'h3D, a1); byte_wr(8'h11, a2);
        sccb_stop();
        check("rs_we_count", 32'(we_cnt - we0), 32'd1);
        check("rs_we_addr",  32'(we_addr), 32'h3D);
        check("rs_we_data",  32'(we_data), 32'h11);

        // reset during the SUB_ACK low drive
        sccb_start();
        byte_wr(8'hCC, a0);
        for (int i = 7; i >= 0; i--) bit_io(1'b1 ^ (i == 7 || i == 3), s);
        check("ack_drive_low", 32'(sio_d), 32'h0);
        reset = 1'b0;
        #1;
        check("rst_release", 32'(sio_d), 32'h1);
        check("rst_mid_addr", 32'(reg_addr), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'h0);
        #(2*Q-1);
        reset = 1'b1;
        sccb_stop();
        we0 = we_cnt;
        sccb_start();
        byte_wr(8'hCC, a0); byte_wr(8'h44, a1); byte_wr(8'h99, a2);
        sccb_stop();
        check("post_rst_acks", 32'({a0, a1, a2}), 32'h7);
        check("post_rst_we",   32'(we_cnt - we0), 32'd1);
        check("post_rst_addr", 32'(we_addr), 32'h44);
        check("post_rst_data", 32'(we_data), 32'h99);

        // 2-phase write sets the sub-address without a strobe
        we0 = we_cnt;
        sccb_start();
        byte_wr(8'hCC, a0); byte_wr(8'h0A, a1);
        sccb_stop();
        check("2ph_no_we",    32'(we_cnt - we0), 32'd0);
        check("2ph_reg_addr", 32'(reg_addr), 32'h0A);

        reg_rdata = 8'h76;
        re0 = re_cnt; drv0 = drv_cnt;
        sccb_start();
        byte_wr(8'hCD, a0);
        byte_rd(rd, na);
        sccb_stop();
`ifdef SCCB_SLV_READ_EN
        check("rd_ack_addr", 32'(a0), 32'h1);
        check("rd_data",     32'(rd), 32'h76);
        check("rd_na_slot",  32'(na), 32'h1);
        check("rd_re_count", 32'(re_cnt - re0), 32'd1);
        check("rd_reg_addr", 32'(reg_addr), 32'h0A);
`else
        check("nord_ack_addr", 32'(a0), 32'h0);
        check("nord_data",     32'(rd), 32'hFF);
        check("nord_re_count", 32'(re_cnt - re0), 32'd0);
        check("nord_no_drive", 32'(drv_cnt - drv0), 32'd0);
`endif
        check("rd_busy_end", 32'(busy), 32'h0);
        check("we_re_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
